fifo_burst_drain: RTL and testbench

// - Downstream consumer of a fifo core: drains words through the fifoConnect.reader modport.
// - Presents them as a valid/ready stream with a 2-entry registered output (skid) buffer.
// - Optional burst gating: words leave only in groups of BURSTLEN, with out_last on the final word.
// - Sits between a fifo instance and a ready-throttled sink (DMA/packetiser).

---
 rtl/libfifo_pkg.sv | 45 ++++
 rtl/fifoConnect.sv | 35 +++
 rtl/stream_skid2.sv | 77 +++++++
 rtl/fifo_burst_drain.sv | 124 ++++++++++++
 tb/tb_fifo_burst_drain.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/libfifo_pkg.sv
// Shared fifo types: status flags, output-enable controls and the drain FSM states.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package libfifo_pkg;

    // Occupancy flags published by a fifo core next to its fill level.
    typedef struct packed {
        logic full;
        logic empty;
    } fill_status_t;

    // Which fifo outputs are driven onto the link.
    typedef enum logic [1:0] {
        OE_NONE   = 2'd0,
        OE_DATA   = 2'd1,
        OE_STATUS = 2'd2,
        OE_ALL    = 2'd3
    } fifo_output_enable_e;

    typedef struct packed {
        logic data_en;
        logic status_en;
    } fifo_output_enable_flags_t;

    // Drain FSM: IDLE waits for a full burst or a flush, BURST and FLUSH pop words.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } drain_state_t;

    // Expand an output-enable mode into individual enable flags.
    function automatic fifo_output_enable_flags_t oe_decode(input fifo_output_enable_e mode);
        fifo_output_enable_flags_t flags;
        flags.data_en   = (mode == OE_DATA)   || (mode == OE_ALL);
        flags.status_en = (mode == OE_STATUS) || (mode == OE_ALL);
        return flags;
    endfunction

    // Width of a fill-level field able to hold 0..depth.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifoConnect.sv
// Link between a show-ahead fifo core and its producer/consumer.
// Latency: none (wires only).
// Backpressure: consumer pops with a 1-cycle read pulse while fillStatus.empty is low.
interface fifoConnect #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int LVL_W = libfifo_pkg::level_width(DEPTH);

    logic [WIDTH-1:0]           dataout;
    libfifo_pkg::fill_status_t  fillStatus;
    logic [LVL_W-1:0]           fillLevel;
    logic                       read;
    logic                       write;
    logic [WIDTH-1:0]           datain;

    modport reader (
        input  dataout,
        input  fillStatus,
        input  fillLevel,
        output read,
        output write,
        output datain
    );

    modport writer (
        output dataout,
        output fillStatus,
        output fillLevel,
        input  read,
        input  write,
        input  datain
    );

endinterface

// File: rtl/stream_skid2.sv
// Two-entry registered valid/ready buffer, FIFO order, head entry drives the output.
// Latency: 1 cycle from accepted input to out_vld.
// Backpressure: in_rdy comes only from registered occupancy (low when both entries are full).
module stream_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);

    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push;
    logic             pop;

    assign in_rdy  = (occ_q != 2'd2);
    assign out_vld = (occ_q != 2'd0);
    assign out_dat = head_q;
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    // Entry update: a new word lands in the first free slot; a pop promotes the tail to the head.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push, pop})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    head_d = in_dat;
                end else begin
                    tail_d = in_dat;
                end
            end
            2'b01: begin
                occ_d = occ_q - 2'd1;
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                end
            end
            2'b11: begin
                // Occupancy unchanged; push only happens with a free slot, so occ is 1 here
                // unless a future caller widens in_rdy.
                if (occ_q == 2'd1) begin
                    head_d = in_dat;
                end else begin
                    head_d = tail_q;
                    tail_d = in_dat;
                end
            end
            default: begin
            end
        endcase
    end

    // Entry registers; reset empties the buffer and clears the visible output word.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: rtl/fifo_burst_drain.sv
// Drains a show-ahead fifo in bursts of BURSTLEN words (or a flushed partial burst) onto a valid/ready stream.
// Latency: first pop the cycle after leaving IDLE, out_valid one cycle after that pop.
// Backpressure: pops stop when the 2-entry output buffer is full; nothing is dropped while out_ready is low.
module fifo_burst_drain
    import libfifo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int BURSTLEN = 1
) (
    input  logic             clk,
    input  logic             reset,
    fifoConnect.reader       link,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    localparam int LVL_W = level_width(DEPTH);
    localparam int CNT_W = $clog2(BURSTLEN + 1);
    localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURSTLEN);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] ONE_LVL   = LVL_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BURSTLEN - 1);

    drain_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LVL_W-1:0] level;
    logic             fifo_empty;
    logic             pop;
    logic             pop_last;
    logic             skid_in_rdy;
    logic [WIDTH:0]   skid_out_dat;

    assign fifo_empty = link.fillStatus.empty;

    // A power-of-two fifo reports fillLevel 0 when full; the full flag restores the true count.
    assign level = link.fillStatus.full ? FULL_LVL : link.fillLevel;

    // Next state, burst counter and pop decision; pop depends only on registered state and occupancy.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        pop_last = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (level >= BURST_LVL) begin
                    state_d = BURST;
                end else if (flush && !fifo_empty) begin
                    state_d = FLUSH;
                end
            end
            BURST: begin
                // An empty fifo here simply stalls the burst; flush is not looked at.
                pop = !fifo_empty && skid_in_rdy;
                if (pop) begin
                    if (cnt_q == LAST_CNT) begin
                        pop_last = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                pop = !fifo_empty && skid_in_rdy;
                if (pop) begin
                    if ((level == ONE_LVL) || (cnt_q == LAST_CNT)) begin
                        pop_last = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and burst counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read-only consumer: the write side of the link is held inactive.
    assign link.read   = pop;
    assign link.write  = 1'b0;
    assign link.datain = '0;

    // Output buffer carries the last tag alongside each captured word.
    stream_skid2 #(
        .WIDTH (WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (pop),
        .in_rdy  (skid_in_rdy),
        .in_dat  ({pop_last, link.dataout}),
        .out_vld (out_valid),
        .out_rdy (out_ready),
        .out_dat (skid_out_dat)
    );

    assign out_last = skid_out_dat[WIDTH];
    assign out_data = skid_out_dat[WIDTH-1:0];
    assign busy     = (state_q != IDLE) || out_valid;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Three drain instances (BURSTLEN 4, 1, 16) each fed by a DEPTH=16 power-of-two show-ahead fifo model.
// Words are queued in a scoreboard when written and compared at each out_valid && out_ready handshake.
// Directed steps run in one initial block; the scoreboard monitor runs inside the tick task.
module tb_fifo_burst_drain;

    localparam int NCH = 3;

    logic clk = 1'b0;
    logic reset;

    logic       wr_en    [NCH];
    logic [7:0] wr_dat   [NCH];
    logic       flush_i  [NCH];
    logic       rdy      [NCH];
    logic [7:0] o_data   [NCH];
    logic       o_valid  [NCH];
    logic       o_last   [NCH];
    logic       o_busy   [NCH];
    logic       o_read   [NCH];
    logic       o_write  [NCH];
    logic [7:0] o_datain [NCH];
    logic [4:0] f_cnt    [NCH];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        localparam int BL = (g == 0) ? 4 : ((g == 1) ? 1 : 16);

        fifoConnect #(.WIDTH(8), .DEPTH(16)) lnk ();

        logic [7:0] mem [16];
        logic [3:0] wp;
        logic [3:0] rp;
        logic [4:0] cnt;
        logic       do_wr;
        logic       do_rd;

        assign do_rd = lnk.read && (cnt != 5'd0);
        assign do_wr = wr_en[g] && (cnt != 5'd16);

        always @(posedge clk) begin
            if (reset) begin
                wp  <= 4'd0;
                rp  <= 4'd0;
                cnt <= 5'd0;
            end else begin
                if (do_wr) begin
                    mem[wp] <= wr_dat[g];
                    wp      <= wp + 4'd1;
                end
                if (do_rd) begin
                    rp <= rp + 4'd1;
                end
                cnt <= cnt + {4'd0, do_wr} - {4'd0, do_rd};
            end
        end

        assign lnk.dataout    = mem[rp];
        assign lnk.fillStatus = '{full: (cnt == 5'd16), empty: (cnt == 5'd0)};
        assign lnk.fillLevel  = {1'b0, cnt[3:0]};
        assign f_cnt[g]       = cnt;
        assign o_read[g]      = lnk.read;
        assign o_write[g]     = lnk.write;
        assign o_datain[g]    = lnk.datain;

        fifo_burst_drain #(
            .WIDTH    (8),
            .DEPTH    (16),
            .BURSTLEN (BL)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .link      (lnk),
            .flush     (flush_i[g]),
            .out_data  (o_data[g]),
            .out_valid (o_valid[g]),
            .out_last  (o_last[g]),
            .out_ready (rdy[g]),
            .busy      (o_busy[g])
        );
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [10:0] exp_q [$];
    bit          rate_en   [NCH];
    bit          have_prev [NCH];
    bit          prev_last [NCH];
    int          last_cyc  [NCH];
    int          delivered [NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Score any handshake that the coming edge will complete, then advance to the next falling edge.
    task automatic tick();
        logic [10:0] e;
        for (int g = 0; g < NCH; g++) begin
            if (o_valid[g] === 1'b1 && rdy[g] === 1'b1) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_extra ch%0d observed=0x%0h expected=none", g, o_data[g]);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_word", {21'd0, 2'(g), o_last[g], o_data[g]}, {21'd0, e});
                    if (rate_en[g] && have_prev[g] && !prev_last[g]) begin
                        chk("burst_rate", cyc, last_cyc[g] + 1);
                    end
                    have_prev[g] = 1'b1;
                    prev_last[g] = o_last[g];
                    last_cyc[g]  = cyc;
                    delivered[g] = delivered[g] + 1;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic wr(input int ch, input logic [7:0] d, input logic last);
        wr_en[ch]  = 1'b1;
        wr_dat[ch] = d;
        exp_q.push_back({2'(ch), last, d});
        tick();
        wr_en[ch] = 1'b0;
    endtask

    task automatic drain(input int ch, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || o_busy[ch] !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        chk("drain_busy", {31'd0, o_busy[ch]}, 0);
        chk("drain_valid", {31'd0, o_valid[ch]}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        int seen;
        int bad;
        int sent;
        logic [7:0] d;

        for (int g = 0; g < NCH; g++) begin
            wr_en[g]     = 1'b0;
            wr_dat[g]    = 8'd0;
            flush_i[g]   = 1'b0;
            rdy[g]       = 1'b1;
            rate_en[g]   = (g != 1);
            have_prev[g] = 1'b0;
            prev_last[g] = 1'b0;
            last_cyc[g]  = 0;
            delivered[g] = 0;
        end
        reset = 1'b1;
        repeat (3) tick();

        // Reset values on every instance.
        for (int g = 0; g < NCH; g++) begin
            chk("rst_valid",  {31'd0, o_valid[g]}, 0);
            chk("rst_last",   {31'd0, o_last[g]}, 0);
            chk("rst_data",   {24'd0, o_data[g]}, 0);
            chk("rst_busy",   {31'd0, o_busy[g]}, 0);
            chk("rst_read",   {31'd0, o_read[g]}, 0);
            chk("rst_write",  {31'd0, o_write[g]}, 0);
            chk("rst_datain", {24'd0, o_datain[g]}, 0);
        end
        reset = 1'b0;
        tick();

        // Two full bursts of 4, sink always ready.
        for (int i = 0; i < 8; i++) wr(0, 8'h10 + 8'(i), (i % 4) == 3);
        drain(0, 100);

        // Partial burst waits for flush.
        for (int i = 0; i < 3; i++) wr(0, 8'hA0 + 8'(i), i == 2);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (o_valid[0] !== 1'b0 || o_busy[0] !== 1'b0) seen++;
        end
        chk("no_early_output", seen, 0);
        chk("partial_in_fifo", {27'd0, f_cnt[0]}, 3);
        base = delivered[0];
        flush_i[0] = 1'b1;
        tick();
        flush_i[0] = 1'b0;
        drain(0, 100);
        chk("flush_count", delivered[0] - base, 3);

        // Sink stalled: exactly two words captured, read low, output word stable.
        rdy[0] = 1'b0;
        for (int i = 0; i < 8; i++) wr(0, 8'h30 + 8'(i), (i % 4) == 3);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_read[0] !== 1'b0 || o_valid[0] !== 1'b1 || o_data[0] !== 8'h30) bad++;
        end
        chk("stall_stable", bad, 0);
        chk("stall_fifo_cnt", {27'd0, f_cnt[0]}, 6);
        chk("stall_last", {31'd0, o_last[0]}, 0);
        base = delivered[0];
        rdy[0] = 1'b1;
        drain(0, 100);
        chk("stall_count", delivered[0] - base, 8);

        // BURSTLEN 1 with a randomly throttled sink.
        sent = 0;
        n = 0;
        base = delivered[1];
        while ((sent < 200 || exp_q.size() != 0) && n < 4000) begin
            rdy[1] = 1'($urandom_range(0, 1));
            if (sent < 200 && f_cnt[1] < 5'd16) begin
                d = 8'($urandom);
                wr_en[1]  = 1'b1;
                wr_dat[1] = d;
                exp_q.push_back({2'd1, 1'b1, d});
                sent++;
            end else begin
                wr_en[1] = 1'b0;
            end
            tick();
            n++;
        end
        wr_en[1] = 1'b0;
        rdy[1]   = 1'b1;
        drain(1, 100);
        chk("rand_count", delivered[1] - base, 200);

        // Reset after two words of a burst.
        for (int i = 0; i < 4; i++) wr(0, 8'h50 + 8'(i), i == 3);
        base = delivered[0];
        n = 0;
        while (delivered[0] < base + 2 && n < 50) begin
            tick();
            n++;
        end
        chk("pre_reset_words", delivered[0] - base, 2);
        rdy[0] = 1'b0;
        reset  = 1'b1;
        tick();
        chk("midrst_valid", {31'd0, o_valid[0]}, 0);
        chk("midrst_read",  {31'd0, o_read[0]}, 0);
        chk("midrst_busy",  {31'd0, o_busy[0]}, 0);
        chk("midrst_last",  {31'd0, o_last[0]}, 0);
        chk("midrst_data",  {24'd0, o_data[0]}, 0);
        exp_q.delete();
        for (int g = 0; g < NCH; g++) have_prev[g] = 1'b0;
        reset  = 1'b0;
        rdy[0] = 1'b1;
        tick();
        base = delivered[0];
        for (int i = 0; i < 4; i++) wr(0, 8'h60 + 8'(i), i == 3);
        drain(0, 100);
        chk("post_reset_count", delivered[0] - base, 4);

        // BURSTLEN 16: burst only starts once the fifo reads full (fillLevel wraps to 0).
        base = delivered[2];
        for (int i = 0; i < 15; i++) wr(2, 8'hC0 + 8'(i), 1'b0);
        repeat (5) tick();
        chk("b16_wait_valid", {31'd0, o_valid[2]}, 0);
        chk("b16_wait_busy",  {31'd0, o_busy[2]}, 0);
        chk("b16_wait_cnt",   {27'd0, f_cnt[2]}, 15);
        wr(2, 8'hCF, 1'b1);
        drain(2, 200);
        chk("b16_count", delivered[2] - base, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
